// File: rtl/itcm_auto_loader.sv
// itcm_auto_loader
// Boot-time AHB master that copies a flash image into the ITCM before the
// core starts fetching. The flash is read one word at a time with single,
// non-pipelined AHB transfers. Each word is then written through the ITCM
// load port. The block ends in a terminal DONE or ERR state.
//
// Handshakes:
//   AHB    - an address phase (HTRANS_m=NONSEQ) completes on the edge where
//            HREADY_m=1. The data phase completes on the next edge with
//            HREADY_m=1. HRESP_m is only honoured on that edge.
//   ITCM   - itcm_load_wr is the valid. itcm_load_addr and itcm_load_wdata
//            are held stable while itcm_load_wr=1. The write transfers on the
//            edge where itcm_load_wr=1 and itcm_load_ready=1.
//
// Optional feature: define ITCM_AUTO_LOAD_CSUM_EN to add a running checksum
// (load_checksum) of every accepted ITCM write. That build also checks the
// final sum against expected_checksum.
//
// All outputs are registered. The FSM state is held in the enum signal
// 'state' so checkers can bind to it.
module itcm_auto_loader #(
  parameter logic [31:0] FLASH_BASE = 32'h0000_0000,
  parameter int          ITCM_WORDS = 4096,
  parameter int          ITCM_AW    = 12
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               load_en,
  output logic [31:0]        HADDR_m,
  output logic [1:0]         HTRANS_m,
  output logic [2:0]         HSIZE_m,
  output logic [2:0]         HBURST_m,
  output logic               HWRITE_m,
  input  logic               HREADY_m,
  input  logic [1:0]         HRESP_m,
  input  logic [31:0]        HRDATA_m,
  output logic               itcm_load_wr,
  output logic [ITCM_AW-1:0] itcm_load_addr,
  output logic [31:0]        itcm_load_wdata,
  input  logic               itcm_load_ready,
  output logic               itcm_auto_load,
  output logic               load_done,
  output logic               load_error
`ifdef ITCM_AUTO_LOAD_CSUM_EN
  ,
  output logic [31:0]        load_checksum,
  input  logic [31:0]        expected_checksum
`endif
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;

  // Index of the final word; the counter never goes past it.
  localparam logic [ITCM_AW:0] LAST_CNT = (ITCM_AW+1)'(ITCM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [ITCM_AW:0]   cnt;
  logic [ITCM_AW:0]   cnt_n;
  logic [31:0]        haddr_n;
  logic [1:0]         htrans_n;
  logic               wr_n;
  logic [ITCM_AW-1:0] laddr_n;
  logic [31:0]        wdata_n;
  logic               auto_load_n;
  logic               done_n;
  logic               error_n;
`ifdef ITCM_AUTO_LOAD_CSUM_EN
  logic [31:0]        csum_n;
`endif

  // The transfer shape never changes: single-word reads.
  assign HSIZE_m  = 3'b010;
  assign HBURST_m = 3'b000;
  assign HWRITE_m = 1'b0;

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    htrans_n = HTRANS_m;
    wr_n     = itcm_load_wr;
    laddr_n  = itcm_load_addr;
    wdata_n  = itcm_load_wdata;
`ifdef ITCM_AUTO_LOAD_CSUM_EN
    csum_n   = load_checksum;
`endif
    case (state)
      S_IDLE: begin
        if (load_en) begin
          state_n  = S_ADDR;
          htrans_n = HTRANS_NONSEQ;
        end else begin
          state_n  = S_DONE;
        end
      end
      S_ADDR: begin
        if (HREADY_m) begin
          state_n  = S_DATA;
          htrans_n = HTRANS_IDLE;
        end
      end
      S_DATA: begin
        // An ERROR cycle with HREADY_m=0 is only the first half of the
        // two-cycle response, so it is ignored here.
        if (HREADY_m) begin
          if (HRESP_m != HRESP_OKAY) begin
            state_n = S_ERR;
          end else begin
            wdata_n = HRDATA_m;
            laddr_n = cnt[ITCM_AW-1:0];
            wr_n    = 1'b1;
            state_n = S_WR;
          end
        end
      end
      S_WR: begin
        if (itcm_load_ready) begin
          wr_n = 1'b0;
`ifdef ITCM_AUTO_LOAD_CSUM_EN
          csum_n = load_checksum + itcm_load_wdata;
`endif
          if (cnt == LAST_CNT) begin
`ifdef ITCM_AUTO_LOAD_CSUM_EN
            state_n = (csum_n == expected_checksum) ? S_DONE : S_ERR;
`else
            state_n = S_DONE;
`endif
          end else begin
            cnt_n    = cnt + (ITCM_AW+1)'(1);
            state_n  = S_ADDR;
            htrans_n = HTRANS_NONSEQ;
          end
        end
      end
      S_DONE, S_ERR: begin
        // Terminal until reset.
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    haddr_n     = FLASH_BASE + 32'({cnt_n, 2'b00});
    auto_load_n = !((state_n == S_DONE) || (state_n == S_ERR));
    done_n      = (state_n == S_DONE) || (state_n == S_ERR);
    error_n     = (state_n == S_ERR);
  end

  // State, counter and every output are registered together.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state           <= S_IDLE;
      cnt             <= '0;
      HADDR_m         <= FLASH_BASE;
      HTRANS_m        <= HTRANS_IDLE;
      itcm_load_wr    <= 1'b0;
      itcm_load_addr  <= '0;
      itcm_load_wdata <= '0;
      itcm_auto_load  <= 1'b1;
      load_done       <= 1'b0;
      load_error      <= 1'b0;
`ifdef ITCM_AUTO_LOAD_CSUM_EN
      load_checksum   <= '0;
`endif
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      HADDR_m         <= haddr_n;
      HTRANS_m        <= htrans_n;
      itcm_load_wr    <= wr_n;
      itcm_load_addr  <= laddr_n;
      itcm_load_wdata <= wdata_n;
      itcm_auto_load  <= auto_load_n;
      load_done       <= done_n;
      load_error      <= error_n;
`ifdef ITCM_AUTO_LOAD_CSUM_EN
      load_checksum   <= csum_n;
`endif
    end
  end

endmodule

// File: tb/tb_itcm_auto_loader.sv
// tb_itcm_auto_loader
// Bench for itcm_auto_loader. It contains a behavioural flash AHB slave
// (with wait states and a two-cycle ERROR response), an ITCM load-port
// model with stalls, and scenario tasks. The tasks compare the logged
// traffic and timing against values derived from the copy rules.
module tb_itcm_auto_loader;

  localparam logic [31:0] FLASH_BASE = 32'h0010_0000;
  localparam int          N          = 4;
  localparam int          AW         = 12;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          load_en = 1'b0;
  logic [31:0]   HADDR_m;
  logic [1:0]    HTRANS_m;
  logic [2:0]    HSIZE_m;
  logic [2:0]    HBURST_m;
  logic          HWRITE_m;
  logic          HREADY_m = 1'b1;
  logic [1:0]    HRESP_m = 2'b00;
  logic [31:0]   HRDATA_m = 32'h0;
  logic          itcm_load_wr;
  logic [AW-1:0] itcm_load_addr;
  logic [31:0]   itcm_load_wdata;
  logic          itcm_load_ready = 1'b1;
  logic          itcm_auto_load;
  logic          load_done;
  logic          load_error;
`ifdef ITCM_AUTO_LOAD_CSUM_EN
  logic [31:0]   load_checksum;
  logic [31:0]   expected_checksum = 32'h0;
`endif

  itcm_auto_loader #(
    .FLASH_BASE(FLASH_BASE),
    .ITCM_WORDS(N),
    .ITCM_AW(AW)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .load_en(load_en),
    .HADDR_m(HADDR_m),
    .HTRANS_m(HTRANS_m),
    .HSIZE_m(HSIZE_m),
    .HBURST_m(HBURST_m),
    .HWRITE_m(HWRITE_m),
    .HREADY_m(HREADY_m),
    .HRESP_m(HRESP_m),
    .HRDATA_m(HRDATA_m),
    .itcm_load_wr(itcm_load_wr),
    .itcm_load_addr(itcm_load_addr),
    .itcm_load_wdata(itcm_load_wdata),
    .itcm_load_ready(itcm_load_ready),
    .itcm_auto_load(itcm_auto_load),
    .load_done(load_done),
    .load_error(load_error)
`ifdef ITCM_AUTO_LOAD_CSUM_EN
    ,
    .load_checksum(load_checksum),
    .expected_checksum(expected_checksum)
`endif
  );

  // ---------------- clock ----------------
  always #5 HCLK = ~HCLK;

  // ---------------- bench state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] flash_mem [N];
  logic [31:0] exp_q [$];
  logic [31:0] addr_q [$];
  logic [AW-1:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  int   cyc = 0;
  int   fall_cyc = -1;
  int   waits = 0;
  int   err_idx = -1;
  int   stall_idx = -1;
  int   stall_cycles = 0;
  int   stall_left = 0;
  int   stab_err = 0;
  bit   dp_active = 1'b0;
  bit   dp_err = 1'b0;
  bit   err_first = 1'b0;
  int   wait_left = 0;
  int   dp_idx = 0;
  int   rd_cnt = 0;
  logic          prev_hready = 1'b1;
  logic [31:0]   prev_haddr = 32'h0;
  logic          prev_wr = 1'b0;
  logic          prev_ready = 1'b1;
  logic [AW-1:0] prev_laddr = '0;
  logic [31:0]   prev_wdata = 32'h0;

  // Flash slave, ITCM port model and traffic monitor. Inputs change on
  // the falling edge, so the DUT sees them settled at the next rising edge.
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      cyc = 0;
      dp_active = 1'b0;
      rd_cnt = 0;
      HREADY_m = 1'b1;
      HRESP_m = 2'b00;
      itcm_load_ready = 1'b1;
      prev_hready = 1'b1;
      prev_wr = 1'b0;
      prev_ready = 1'b1;
    end else begin
      cyc++;
      if (!itcm_auto_load && fall_cyc < 0) fall_cyc = cyc;
      if (!prev_hready && HADDR_m !== prev_haddr) stab_err++;
      if (prev_wr && !prev_ready &&
          (itcm_load_wr !== 1'b1 || itcm_load_addr !== prev_laddr ||
           itcm_load_wdata !== prev_wdata)) stab_err++;
      // Flash side: finish a pending data phase, then look for a new address.
      HRDATA_m = $urandom;
      HRESP_m = 2'b00;
      HREADY_m = 1'b1;
      if (dp_active) begin
        if (wait_left > 0) begin
          HREADY_m = 1'b0;
          wait_left--;
        end else if (dp_err && !err_first) begin
          HREADY_m = 1'b0;
          HRESP_m = 2'b01;
          err_first = 1'b1;
        end else begin
          HREADY_m = 1'b1;
          HRESP_m = dp_err ? 2'b01 : 2'b00;
          HRDATA_m = (dp_idx >= 0 && dp_idx < N) ? flash_mem[dp_idx] : 32'hDEAD_BEEF;
          dp_active = 1'b0;
        end
      end
      if (HTRANS_m == 2'b10 && HREADY_m) begin
        addr_q.push_back(HADDR_m);
        dp_active = 1'b1;
        wait_left = waits;
        dp_err = (rd_cnt == err_idx);
        err_first = 1'b0;
        dp_idx = int'((HADDR_m - FLASH_BASE) >> 2);
        rd_cnt++;
      end
      // ITCM side: optional stall on one word, otherwise accept at once.
      itcm_load_ready = 1'b1;
      if (itcm_load_wr) begin
        if (int'(itcm_load_addr) == stall_idx && stall_left > 0) begin
          itcm_load_ready = 1'b0;
          stall_left--;
        end else begin
          wr_addr_q.push_back(itcm_load_addr);
          wr_data_q.push_back(itcm_load_wdata);
        end
      end
      prev_hready = HREADY_m;
      prev_haddr = HADDR_m;
      prev_wr = itcm_load_wr;
      prev_ready = itcm_load_ready;
      prev_laddr = itcm_load_addr;
      prev_wdata = itcm_load_wdata;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_cfg(input int w, input int s_idx, input int s_cyc, input int e_idx);
    waits = w;
    stall_idx = s_idx;
    stall_cycles = s_cyc;
    err_idx = e_idx;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) flash_mem[i] = $urandom;
  endtask

  // Holds reset for a few cycles, clears the logs and releases just after a falling edge.
  task automatic do_reset(input logic le);
    HRESETn = 1'b0;
    load_en = le;
    repeat (3) @(negedge HCLK);
    addr_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    fall_cyc = -1;
    stab_err = 0;
    stall_left = stall_cycles;
    #1 HRESETn = 1'b1;
  endtask

  // Bounded wait for load_done; the callers check load_done afterwards.
  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (load_done !== 1'b1 && k < budget) begin
      @(negedge HCLK);
      #1;
      k++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_cfg(0, -1, 0, -1);
    HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    #1;
    n_checks++; if (HTRANS_m !== 2'b00) $display("FAIL reset_htrans: got %0h want 0", HTRANS_m); else n_pass++;
    n_checks++; if (HADDR_m !== FLASH_BASE) $display("FAIL reset_haddr: got %0h want %0h", HADDR_m, FLASH_BASE); else n_pass++;
    n_checks++; if (itcm_load_wr !== 1'b0) $display("FAIL reset_wr: got %b want 0", itcm_load_wr); else n_pass++;
    n_checks++; if (itcm_load_addr !== '0) $display("FAIL reset_laddr: got %0h want 0", itcm_load_addr); else n_pass++;
    n_checks++; if (itcm_load_wdata !== 32'h0) $display("FAIL reset_wdata: got %0h want 0", itcm_load_wdata); else n_pass++;
    n_checks++; if (itcm_auto_load !== 1'b1) $display("FAIL reset_auto_load: got %b want 1", itcm_auto_load); else n_pass++;
    n_checks++; if (load_done !== 1'b0) $display("FAIL reset_done: got %b want 0", load_done); else n_pass++;
    n_checks++; if (load_error !== 1'b0) $display("FAIL reset_error: got %b want 0", load_error); else n_pass++;
    n_checks++; if (HSIZE_m !== 3'b010 || HBURST_m !== 3'b000 || HWRITE_m !== 1'b0)
      $display("FAIL fixed_ctrl: got size %0h burst %0h write %b want 2 0 0", HSIZE_m, HBURST_m, HWRITE_m); else n_pass++;
`ifdef ITCM_AUTO_LOAD_CSUM_EN
    n_checks++; if (load_checksum !== 32'h0) $display("FAIL reset_csum: got %0h want 0", load_checksum); else n_pass++;
`endif
  endtask

  task automatic test_basic_copy();
    flash_mem[0] = 32'd11; flash_mem[1] = 32'd22; flash_mem[2] = 32'd33; flash_mem[3] = 32'd44;
    set_cfg(0, -1, 0, -1);
    do_reset(1'b1);
    wait_done(200);
    repeat (3) @(negedge HCLK);
    #1;
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(FLASH_BASE + 32'(4 * i));
    n_checks++; if (addr_q.size() != N) $display("FAIL basic_nreads: got %0d want %0d", addr_q.size(), N); else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++; if (addr_q[i] !== exp_q[i]) $display("FAIL basic_haddr[%0d]: got %0h want %0h", i, addr_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (wr_data_q.size() != N) $display("FAIL basic_nwrites: got %0d want %0d", wr_data_q.size(), N); else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++; if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== flash_mem[i])
        $display("FAIL basic_itcm[%0d]: got addr %0h data %0h want addr %0h data %0h", i, wr_addr_q[i], wr_data_q[i], i, flash_mem[i]); else n_pass++;
    end
    n_checks++; if (fall_cyc != 3 * N + 1) $display("FAIL basic_fall_cycle: got %0d want %0d", fall_cyc, 3 * N + 1); else n_pass++;
    n_checks++; if (load_done !== 1'b1 || load_error !== 1'b0 || itcm_auto_load !== 1'b0)
      $display("FAIL basic_status: got done %b err %b auto %b want 1 0 0", load_done, load_error, itcm_auto_load); else n_pass++;
    n_checks++; if (itcm_load_wr !== 1'b0 || HTRANS_m !== 2'b00)
      $display("FAIL basic_idle_after: got wr %b htrans %0h want 0 0", itcm_load_wr, HTRANS_m); else n_pass++;
  endtask

  task automatic test_wait_states();
    int exp_fall;
    fill_random();
    set_cfg(2, 2, 1, -1);
    do_reset(1'b1);
    wait_done(300);
    repeat (2) @(negedge HCLK);
    #1;
    exp_fall = 3 * N + 1 + N * 2 + 1;
    n_checks++; if (fall_cyc != exp_fall) $display("FAIL wait_fall_cycle: got %0d want %0d", fall_cyc, exp_fall); else n_pass++;
    n_checks++; if (stab_err != 0) $display("FAIL wait_stability: got %0d changes while stalled want 0", stab_err); else n_pass++;
    n_checks++; if (wr_data_q.size() != N) $display("FAIL wait_nwrites: got %0d want %0d", wr_data_q.size(), N); else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++; if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== flash_mem[i] || addr_q[i] !== FLASH_BASE + 32'(4 * i))
        $display("FAIL wait_word[%0d]: got haddr %0h addr %0h data %0h want haddr %0h addr %0h data %0h", i, addr_q[i],
                 wr_addr_q[i], wr_data_q[i], FLASH_BASE + 32'(4 * i), i, flash_mem[i]); else n_pass++;
    end
    n_checks++; if (load_done !== 1'b1 || load_error !== 1'b0) $display("FAIL wait_status: got done %b err %b want 1 0", load_done, load_error); else n_pass++;
  endtask

  task automatic test_bus_error();
    fill_random();
    set_cfg(0, -1, 0, 2);
    do_reset(1'b1);
    wait_done(200);
    repeat (10) @(negedge HCLK);
    #1;
    n_checks++; if (wr_data_q.size() != 2) $display("FAIL err_nwrites: got %0d want 2", wr_data_q.size()); else n_pass++;
    n_checks++; if (wr_data_q[0] !== flash_mem[0] || wr_data_q[1] !== flash_mem[1])
      $display("FAIL err_data: got %0h %0h want %0h %0h", wr_data_q[0], wr_data_q[1], flash_mem[0], flash_mem[1]); else n_pass++;
    n_checks++; if (addr_q.size() != 3) $display("FAIL err_nreads: got %0d want 3", addr_q.size()); else n_pass++;
    n_checks++; if (load_error !== 1'b1 || load_done !== 1'b1 || itcm_auto_load !== 1'b0)
      $display("FAIL err_status: got err %b done %b auto %b want 1 1 0", load_error, load_done, itcm_auto_load); else n_pass++;
    n_checks++; if (HTRANS_m !== 2'b00 || itcm_load_wr !== 1'b0)
      $display("FAIL err_quiet: got htrans %0h wr %b want 0 0", HTRANS_m, itcm_load_wr); else n_pass++;
  endtask

  task automatic test_skip();
    set_cfg(0, -1, 0, -1);
    do_reset(1'b0);
    repeat (2) @(negedge HCLK);
    #1;
    n_checks++; if (load_done !== 1'b1 || itcm_auto_load !== 1'b0)
      $display("FAIL skip_done_2cyc: got done %b auto %b want 1 0", load_done, itcm_auto_load); else n_pass++;
    repeat (10) @(negedge HCLK);
    #1;
    n_checks++; if (addr_q.size() != 0 || wr_data_q.size() != 0)
      $display("FAIL skip_no_traffic: got %0d reads %0d writes want 0 0", addr_q.size(), wr_data_q.size()); else n_pass++;
    n_checks++; if (load_error !== 1'b0) $display("FAIL skip_error: got %b want 0", load_error); else n_pass++;
  endtask

  task automatic test_reset_mid_copy();
    int k;
    fill_random();
    set_cfg(0, -1, 0, -1);
    do_reset(1'b1);
    k = 0;
    while (!(itcm_load_wr === 1'b1 && itcm_load_addr === AW'(1)) && k < 50) begin
      @(negedge HCLK);
      #1;
      k++;
    end
    n_checks++; if (k >= 50) $display("FAIL midrst_reach_wr1: got timeout want write of word 1"); else n_pass++;
    #1 HRESETn = 1'b0;
    #1;
    n_checks++; if (HTRANS_m !== 2'b00 || HADDR_m !== FLASH_BASE || itcm_load_wr !== 1'b0 ||
                    itcm_load_addr !== '0 || itcm_load_wdata !== 32'h0)
      $display("FAIL midrst_bus_reset: got htrans %0h haddr %0h wr %b addr %0h data %0h want 0 %0h 0 0 0",
               HTRANS_m, HADDR_m, itcm_load_wr, itcm_load_addr, itcm_load_wdata, FLASH_BASE); else n_pass++;
    n_checks++; if (itcm_auto_load !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0)
      $display("FAIL midrst_status_reset: got auto %b done %b err %b want 1 0 0", itcm_auto_load, load_done, load_error); else n_pass++;
    do_reset(1'b1);
    wait_done(200);
    #1;
    n_checks++; if (wr_data_q.size() != N || addr_q.size() != N)
      $display("FAIL midrst_counts: got %0d writes %0d reads want %0d %0d", wr_data_q.size(), addr_q.size(), N, N); else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++; if (addr_q[i] !== FLASH_BASE + 32'(4 * i) || wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== flash_mem[i])
        $display("FAIL midrst_word[%0d]: got haddr %0h addr %0h data %0h want %0h %0h %0h", i, addr_q[i], wr_addr_q[i],
                 wr_data_q[i], FLASH_BASE + 32'(4 * i), i, flash_mem[i]); else n_pass++;
    end
    n_checks++; if (load_done !== 1'b1 || load_error !== 1'b0) $display("FAIL midrst_status: got done %b err %b want 1 0", load_done, load_error); else n_pass++;
  endtask

  task automatic test_random_stalls();
    int w, s_i, s_c, exp_fall;
    for (int it = 0; it < 4; it++) begin
      fill_random();
      w = $urandom_range(0, 3);
      s_i = $urandom_range(0, N - 1);
      s_c = $urandom_range(0, 3);
      set_cfg(w, s_i, s_c, -1);
      do_reset(1'b1);
      wait_done(400);
      repeat (2) @(negedge HCLK);
      #1;
      exp_fall = 3 * N + 1 + N * w + s_c;
      n_checks++; if (fall_cyc != exp_fall) $display("FAIL rand%0d_fall: got %0d want %0d (waits %0d stall %0d)", it, fall_cyc, exp_fall, w, s_c); else n_pass++;
      n_checks++; if (stab_err != 0) $display("FAIL rand%0d_stability: got %0d want 0", it, stab_err); else n_pass++;
      exp_q.delete();
      for (int i = 0; i < N; i++) exp_q.push_back(flash_mem[i]);
      n_checks++; if (wr_data_q.size() != N) $display("FAIL rand%0d_nwrites: got %0d want %0d", it, wr_data_q.size(), N); else n_pass++;
      for (int i = 0; i < N; i++) begin
        n_checks++; if (wr_data_q[i] !== exp_q[i] || wr_addr_q[i] !== AW'(i))
          $display("FAIL rand%0d_word[%0d]: got addr %0h data %0h want %0h %0h", it, i, wr_addr_q[i], wr_data_q[i], i, exp_q[i]); else n_pass++;
      end
    end
  endtask

`ifdef ITCM_AUTO_LOAD_CSUM_EN
  task automatic test_checksum();
    logic [31:0] sum;
    for (int i = 0; i < N; i++) flash_mem[i] = 32'(i + 1);
    sum = 32'h0;
    for (int i = 0; i < N; i++) sum = sum + flash_mem[i];
    set_cfg(0, -1, 0, -1);
    expected_checksum = sum;
    do_reset(1'b1);
    wait_done(200);
    #1;
    n_checks++; if (load_checksum !== sum) $display("FAIL csum_value: got %0h want %0h", load_checksum, sum); else n_pass++;
    n_checks++; if (load_error !== 1'b0 || load_done !== 1'b1) $display("FAIL csum_good: got err %b done %b want 0 1", load_error, load_done); else n_pass++;
    expected_checksum = sum + 32'd1;
    do_reset(1'b1);
    wait_done(200);
    #1;
    n_checks++; if (load_error !== 1'b1 || load_done !== 1'b1) $display("FAIL csum_bad: got err %b done %b want 1 1", load_error, load_done); else n_pass++;
    n_checks++; if (load_checksum !== sum) $display("FAIL csum_bad_value: got %0h want %0h", load_checksum, sum); else n_pass++;
    n_checks++; if (wr_data_q.size() != N) $display("FAIL csum_bad_nwrites: got %0d want %0d", wr_data_q.size(), N); else n_pass++;
  endtask
`endif

  // Safety net so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_copy();
    test_wait_states();
    test_bus_error();
    test_skip();
    test_reset_mid_copy();
    test_random_stalls();
`ifdef ITCM_AUTO_LOAD_CSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
